pio_seq_ctrl: RTL and testbench

Hardware pattern sequencer and write arbiter for the 4-bit output PIO. It sits between the Nios II data master and the PIO's Avalon-MM slave. The CPU loads up to 8 four-bit patterns, a step period and a length; the block then plays them to the PIO autonomously. CPU direct writes are forwarded through the same master port with priority.

---
 rtl/pio_seq_pkg.sv | 33 +++
 rtl/pio_seq_regs.sv | 135 +++++++++++++
 rtl/pio_seq_ctrl.sv | 147 ++++++++++++++
 tb/tb_pio_seq_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_seq_pkg.sv
// pio_seq_pkg: shared register map, CTRL/STATUS bit positions and
// sequencer state encoding for the PIO pattern sequencer.
package pio_seq_pkg;

    // CPU slave word addresses; PATTERN entries live at 8..15 (address[3]=1)
    localparam logic [3:0] A_CTRL   = 4'd0;
    localparam logic [3:0] A_PERIOD = 4'd1;
    localparam logic [3:0] A_LENGTH = 4'd2;
    localparam logic [3:0] A_DIRECT = 4'd3;
    localparam logic [3:0] A_STATUS = 4'd4;

    // CTRL bits
    localparam int CTRL_RUN    = 0;
    localparam int CTRL_LOOP   = 1;
    localparam int CTRL_IRQ_EN = 2;

    // STATUS bits
    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_IDX_LSB = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_STEP = 2'd1,
        S_WAIT = 2'd2
    } seq_state_t;

    // PATTERN window decode
    function automatic logic is_pattern_addr(input logic [3:0] a);
        return a[3];
    endfunction

endpackage

// File: rtl/pio_seq_regs.sv
// pio_seq_regs: CPU-visible register file, PATTERN storage and the
// zero-wait-state readdata mux for pio_seq_ctrl.
// Optional feature macro: PIO_SEQ_IRQ_EN (adds CTRL.IRQ_EN and a registered irq).
module pio_seq_regs
    import pio_seq_pkg::*;
#(
    parameter int PERIOD_W = 16,
    parameter int DEPTH    = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [3:0]                 address,
    input  logic                       chipselect,
    input  logic                       write_n,
    input  logic [31:0]                writedata,
    output logic [31:0]                readdata,
    input  logic                       busy,
    input  logic [$clog2(DEPTH)-1:0]   cur_idx,
    input  logic [$clog2(DEPTH)-1:0]   fetch_idx,
    input  logic [3:0]                 last_val,
    input  logic                       done_set,
    input  logic                       run_clr,
    output logic                       loop,
    output logic [PERIOD_W-1:0]        period,
    output logic [$clog2(DEPTH)-1:0]   length,
    output logic [3:0]                 pat_q,
    output logic                       irq
);

    localparam int IW = $clog2(DEPTH);

    logic                  wr;
    logic                  ctrl_wr;
    logic                  run;
    logic                  run_nx;
    logic                  done;
    logic                  done_nx;
    logic [DEPTH-1:0][3:0] pattern;
    logic                  unused_wd;

    assign wr        = chipselect & ~write_n;
    assign ctrl_wr   = wr && (address == A_CTRL);
    assign pat_q     = pattern[fetch_idx];
    assign unused_wd = ^writedata;

`ifdef PIO_SEQ_IRQ_EN
    logic irq_en;
    logic irq_en_nx;
`endif

    // Next values of the bits the sequencer can also modify; set beats clear
    always_comb begin
        run_nx  = run;
        done_nx = done;
        if (ctrl_wr)
            run_nx = writedata[CTRL_RUN];
        if (run_clr)
            run_nx = 1'b0;
        if (wr && (address == A_STATUS) && writedata[STAT_DONE])
            done_nx = 1'b0;
        if (done_set)
            done_nx = 1'b1;
`ifdef PIO_SEQ_IRQ_EN
        irq_en_nx = irq_en;
        if (ctrl_wr)
            irq_en_nx = writedata[CTRL_IRQ_EN];
`endif
    end

    // Register file and pattern storage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run     <= 1'b0;
            done    <= 1'b0;
            loop    <= 1'b0;
            period  <= '0;
            length  <= '0;
            pattern <= '0;
        end else begin
            run  <= run_nx;
            done <= done_nx;
            if (ctrl_wr)
                loop <= writedata[CTRL_LOOP];
            if (wr && (address == A_PERIOD))
                period <= writedata[PERIOD_W-1:0];
            if (wr && (address == A_LENGTH))
                length <= writedata[IW-1:0];
            if (wr && is_pattern_addr(address))
                pattern[address[IW-1:0]] <= writedata[3:0];
        end
    end

`ifdef PIO_SEQ_IRQ_EN
    // irq follows DONE&IRQ_EN with no extra lag: computed from next values
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            irq_en <= irq_en_nx;
            irq    <= done_nx & irq_en_nx;
        end
    end
`else
    assign irq = 1'b0;
`endif

    // Readback mux, unused bits zero
    always_comb begin
        readdata = '0;
        if (is_pattern_addr(address)) begin
            readdata[3:0] = pattern[address[IW-1:0]];
        end else begin
            case (address)
                A_CTRL: begin
                    readdata[CTRL_RUN]  = run;
                    readdata[CTRL_LOOP] = loop;
`ifdef PIO_SEQ_IRQ_EN
                    readdata[CTRL_IRQ_EN] = irq_en;
`endif
                end
                A_PERIOD: readdata[PERIOD_W-1:0] = period;
                A_LENGTH: readdata[IW-1:0]       = length;
                A_DIRECT: readdata[3:0]          = last_val;
                A_STATUS: begin
                    readdata[STAT_BUSY]             = busy;
                    readdata[STAT_DONE]             = done;
                    readdata[STAT_IDX_LSB +: IW]    = cur_idx;
                end
                default: readdata = '0;
            endcase
        end
    end

endmodule

// File: rtl/pio_seq_ctrl.sv
// pio_seq_ctrl: pattern sequencer and write arbiter in front of the 4-bit
// output PIO. CPU DIRECT writes win over sequencer steps; the PIO master
// outputs are registered so a request seen in cycle N drives the bus in N+1.
// Optional feature macro: PIO_SEQ_IRQ_EN (end-of-sequence interrupt).
module pio_seq_ctrl
    import pio_seq_pkg::*;
#(
    parameter int PERIOD_W = 16,
    parameter int DEPTH    = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        pio_chipselect,
    output logic        pio_write_n,
    output logic [1:0]  pio_address,
    output logic [31:0] pio_writedata,
    output logic        irq
);

    localparam int IW = $clog2(DEPTH);

    seq_state_t          state;
    logic [IW-1:0]       idx;
    logic [IW-1:0]       length;
    logic [IW-1:0]       fetch_idx;
    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] period;
    logic [PERIOD_W-1:0] period_ld;
    logic [3:0]          pat_q;
    logic                loop;
    logic                wr;
    logic                ctrl_wr;
    logic                start;
    logic                stop;
    logic                dir_wr;
    logic                cnt_end;
    logic                seq_issue;
    logic                fin;
    logic                busy;

    assign pio_address = 2'b00;
    assign wr          = chipselect & ~write_n;
    assign ctrl_wr     = wr && (address == A_CTRL);
    assign start       = ctrl_wr &  writedata[CTRL_RUN];
    assign stop        = ctrl_wr & ~writedata[CTRL_RUN];
    assign dir_wr      = wr && (address == A_DIRECT);
    assign busy        = (state != S_IDLE);
    assign period_ld   = (period == '0) ? PERIOD_W'(1) : period;
    assign cnt_end     = (cnt == PERIOD_W'(1));
    // Starting from IDLE issues entry 0 straight away so the first write lands in N+1
    assign fetch_idx   = (state == S_IDLE) ? '0 : idx;
    assign seq_issue   = !stop && (((state == S_IDLE) && start) ||
                                   ((state == S_STEP) && !dir_wr));
    assign fin         = !stop && (state == S_WAIT) && cnt_end &&
                         (idx == length) && !loop;

    pio_seq_regs #(
        .PERIOD_W (PERIOD_W),
        .DEPTH    (DEPTH)
    ) u_regs (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .busy       (busy),
        .cur_idx    (idx),
        .fetch_idx  (fetch_idx),
        .last_val   (pio_writedata[3:0]),
        .done_set   (fin),
        .run_clr    (fin),
        .loop       (loop),
        .period     (period),
        .length     (length),
        .pat_q      (pat_q),
        .irq        (irq)
    );

    // Sequencer FSM, step counter and PIO write arbitration (DIRECT first)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            idx            <= '0;
            cnt            <= '0;
            pio_chipselect <= 1'b0;
            pio_write_n    <= 1'b1;
            pio_writedata  <= '0;
        end else begin
            pio_chipselect <= 1'b0;
            pio_write_n    <= 1'b1;
            if (dir_wr) begin
                pio_chipselect <= 1'b1;
                pio_write_n    <= 1'b0;
                pio_writedata  <= {28'b0, writedata[3:0]};
            end else if (seq_issue) begin
                pio_chipselect <= 1'b1;
                pio_write_n    <= 1'b0;
                pio_writedata  <= {28'b0, pat_q};
            end

            if (stop) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            idx   <= '0;
                            cnt   <= period_ld;
                            state <= S_WAIT;
                        end
                    end
                    S_STEP: begin
                        // stalls here while a DIRECT write takes the bus
                        if (!dir_wr) begin
                            cnt   <= period_ld;
                            state <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (cnt_end) begin
                            if (idx != length) begin
                                idx   <= idx + 1'b1;
                                state <= S_STEP;
                            end else if (loop) begin
                                idx   <= '0;
                                state <= S_STEP;
                            end else begin
                                state <= S_IDLE;
                            end
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pio_seq_ctrl.sv
// tb_pio_seq_ctrl: scoreboard bench for pio_seq_ctrl. Expected PIO writes
// (cycle, data) are queued when stimulus is driven and checked by a monitor.
module tb_pio_seq_ctrl;

`ifdef PIO_SEQ_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    localparam logic [3:0] R_CTRL = 4'd0, R_PER = 4'd1, R_LEN = 4'd2,
                           R_DIR = 4'd3, R_STAT = 4'd4, R_PAT = 4'd8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [1:0]  pio_address;
    logic [31:0] pio_writedata;
    logic        irq;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        int          c;
        logic [31:0] d;
    } exp_t;
    exp_t sbq[$];

    pio_seq_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .address        (address),
        .chipselect     (chipselect),
        .write_n        (write_n),
        .writedata      (writedata),
        .readdata       (readdata),
        .pio_chipselect (pio_chipselect),
        .pio_write_n    (pio_write_n),
        .pio_address    (pio_address),
        .pio_writedata  (pio_writedata),
        .irq            (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void exp_wr(input int c, input logic [31:0] d);
        exp_t e;
        e.c = c;
        e.d = d;
        sbq.push_back(e);
    endfunction

    // PIO monitor: every write must match the head of the scoreboard
    always @(negedge clk) begin
        if (reset_n && pio_chipselect && !pio_write_n) begin
            if (sbq.size() == 0) begin
                chk("pio_unexpected_write", 32'(sbq.size()), 32'd1);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("pio_data",  pio_writedata, e.d);
                chk("pio_cycle", 32'(cyc), 32'(e.c));
                chk("pio_addr",  32'(pio_address), 32'd0);
            end
        end
    end

    // called at posedge+1; one-cycle CPU write, returns at next posedge+1
    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk); #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        address = a;
        @(negedge clk);
        d = readdata;
        @(posedge clk); #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain(input int lim);
        for (int i = 0; i < lim && sbq.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        chk("sb_drain", 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int n;
        int m;
        reset_n    = 1'b0;
        address    = R_STAT;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;

        // reset defaults
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pio_cs",   32'(pio_chipselect), 32'd0);
        chk("rst_pio_wn",   32'(pio_write_n), 32'd1);
        chk("rst_pio_data", pio_writedata, 32'd0);
        chk("rst_irq",      32'(irq), 32'd0);
        chk("rst_status",   readdata, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        rd(R_CTRL, d);
        chk("rst_ctrl", d, 32'd0);

        // single pass: 1,2,4,8 every PERIOD+1 cycles
        wr(R_PAT + 4'd0, 32'd1);
        wr(R_PAT + 4'd1, 32'd2);
        wr(R_PAT + 4'd2, 32'd4);
        wr(R_PAT + 4'd3, 32'd8);
        wr(R_LEN, 32'd3);
        wr(R_PER, 32'd4);
        n = cyc;
        for (int i = 0; i < 4; i++) exp_wr(n + 1 + 5 * i, 32'(1 << i));
        wr(R_CTRL, 32'h5);
        wait_until(n + 19);
        rd(R_STAT, d);
        chk("sp_status_last_wait", d, 32'h31);
        rd(R_STAT, d);
        chk("sp_status_done", d, 32'h32);
        chk("sp_irq_set", 32'(irq), 32'(IRQ_ON));
        drain(40);
        rd(R_CTRL, d);
        chk("sp_ctrl_run_cleared", d, IRQ_ON ? 32'h4 : 32'h0);
        rd(R_DIR, d);
        chk("sp_direct_last", d, 32'd8);

        // DONE clear
        wr(R_STAT, 32'h2);
        chk("clr_irq", 32'(irq), 32'd0);
        rd(R_STAT, d);
        chk("clr_status", d, 32'h30);

        // loop with PERIOD=0, then stop
        wr(R_LEN, 32'd1);
        wr(R_PER, 32'd0);
        n = cyc;
        exp_wr(n + 1, 32'd1);
        exp_wr(n + 3, 32'd2);
        exp_wr(n + 5, 32'd1);
        exp_wr(n + 7, 32'd2);
        wr(R_CTRL, 32'h3);
        wait_until(n + 7);
        wr(R_CTRL, 32'h0);
        repeat (8) begin
            @(posedge clk); #1;
        end
        chk("loop_sb_drain", 32'(sbq.size()), 32'd0);
        rd(R_STAT, d);
        chk("loop_stop_status", d, 32'h10);
        rd(R_CTRL, d);
        chk("loop_stop_ctrl", d, 32'h0);

        // collision: DIRECT in the STEP cycle delays the pattern by one
        wr(R_PAT + 4'd0, 32'd5);
        wr(R_PAT + 4'd1, 32'd6);
        wr(R_PAT + 4'd2, 32'd7);
        wr(R_LEN, 32'd2);
        wr(R_PER, 32'd3);
        n = cyc;
        exp_wr(n + 1,  32'd5);
        exp_wr(n + 5,  32'hF);
        exp_wr(n + 6,  32'd6);
        exp_wr(n + 10, 32'd7);
        wr(R_CTRL, 32'h1);
        wait_until(n + 4);
        wr(R_DIR, 32'hFFFF_FFFF);
        wait_until(n + 14);
        rd(R_STAT, d);
        chk("col_status_done", d, 32'h22);
        chk("col_irq_disabled", 32'(irq), 32'd0);
        drain(10);
        rd(R_DIR, d);
        chk("col_direct_last", d, 32'd7);
        wr(R_STAT, 32'h2);

        // full-depth wrap: indices 0..7, PERIOD=1
        for (int i = 0; i < 8; i++) wr(R_PAT + 4'(i), 32'(i ^ 5));
        wr(R_LEN, 32'd7);
        wr(R_PER, 32'd1);
        n = cyc;
        for (int i = 0; i < 8; i++) exp_wr(n + 1 + 2 * i, 32'(i ^ 5));
        wr(R_CTRL, 32'h1);
        wait_until(n + 15);
        rd(R_STAT, d);
        chk("wrap_status_idx7", d, 32'h71);
        drain(20);
        rd(R_STAT, d);
        chk("wrap_status_done", d, 32'h72);
        m = cyc;
        wr(R_STAT, 32'h2);
        rd(R_STAT, d);
        chk("wrap_clr_status", d, 32'h70);
        chk("wrap_clr_cycle", 32'(cyc - m), 32'd2);

        // reset in the middle of a looping run
        wr(R_PER, 32'd0);
        wr(R_LEN, 32'd1);
        wr(R_CTRL, 32'h3);
        reset_n = 1'b0;
        address = R_STAT;
        #1;
        chk("mrst_pio_cs",   32'(pio_chipselect), 32'd0);
        chk("mrst_pio_wn",   32'(pio_write_n), 32'd1);
        chk("mrst_irq",      32'(irq), 32'd0);
        chk("mrst_status",   readdata, 32'd0);
        chk("mrst_pio_data", pio_writedata, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
        end
        rd(R_PER, d);
        chk("mrst_period", d, 32'd0);
        rd(R_PAT, d);
        chk("mrst_pattern0", d, 32'd0);
        rd(R_DIR, d);
        chk("mrst_direct", d, 32'd0);
        chk("end_sb_empty", 32'(sbq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
